uart_mem_responder: RTL

- Memory-side counterpart of the CPU memory UART link: receives 8N1 request frames on `rx`, serves them from a local word RAM, and returns acknowledge/read-data bytes on `tx`.
- Stands in for the external memory host so the CPU memory path can be closed on-chip or on a second FPGA.
- Contains its own UART byte receiver, UART byte transmitter, frame-parsing FSM and RAM.

---
 rtl/uart_mem_responder_if.sv | 12 +
 rtl/uart_mem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_responder_if.sv
// Serial link and status signals of the UART memory responder.
// The responder takes the slave side; the host model takes the master side.
interface uart_mem_responder_if;
    logic        rx;
    logic        tx;
    logic        busy;
    logic        frame_err;
    logic [15:0] req_count;

    modport slave  (input rx, output tx, busy, frame_err, req_count);
    modport master (output rx, input tx, busy, frame_err, req_count);
endinterface

// File: rtl/uart_mem_responder.sv
// UART memory responder: parses 8N1 read/write request frames, serves them
// from a local word RAM and answers with an ack byte or the read data.
module uart_mem_responder #(
    parameter int unsigned CLKS_PER_BIT   = 868,
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 20 * CLKS_PER_BIT * 10
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_mem_responder_if.slave  bus
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ToW-1:0]  ToLast   = ToW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;
    localparam logic [7:0] RspAck   = 8'h4B;
    localparam logic [7:0] RspErr   = 8'h45;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [2:0] {StIdle, StGetAddr, StGetData, StMem, StSend} state_e;

    // RX engine
    rx_state_e       rx_state_q;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CntW-1:0] rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;
    logic            rx_valid_q, rx_ferr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RxIdle;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= bus.rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            unique case (rx_state_q)
                RxIdle: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RxStart;
                        rx_cnt_q   <= '0;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == HalfLast) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        // A start bit that has gone high again was a glitch.
                        rx_state_q <= rx_sync_q ? RxIdle : RxData;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CntW'(1);
                    end
                end
                RxData: begin
                    if (rx_cnt_q == BitLast) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CntW'(1);
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == BitLast) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RxIdle;
                        rx_valid_q <= rx_sync_q;
                        rx_ferr_q  <= !rx_sync_q;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CntW'(1);
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // TX engine
    tx_state_e       tx_state_q;
    logic [CntW-1:0] tx_cnt_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_shift_q;
    logic            tx_q;
    logic            tx_start_q;
    logic [7:0]      tx_byte;
    logic            tx_done;

    assign tx_done = (tx_state_q == TxStop) && (tx_cnt_q == BitLast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            unique case (tx_state_q)
                TxIdle: begin
                    if (tx_start_q) begin
                        tx_shift_q <= tx_byte;
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TxStart;
                    end
                end
                TxStart: begin
                    if (tx_cnt_q == BitLast) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_state_q <= TxData;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CntW'(1);
                    end
                end
                TxData: begin
                    if (tx_cnt_q == BitLast) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TxStop;
                        end else begin
                            tx_q       <= tx_shift_q[1];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CntW'(1);
                    end
                end
                TxStop: begin
                    if (tx_done) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= TxIdle;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CntW'(1);
                    end
                end
                default: tx_state_q <= TxIdle;
            endcase
        end
    end

    // Frame FSM
    state_e          state_q;
    logic            is_write_q;
    logic [1:0]      byte_cnt_q;
    logic [31:0]     addr_q, wdata_q, resp_q;
    logic [2:0]      resp_left_q;
    logic            load_rd_q;
    logic [ToW-1:0]  to_cnt_q;
    logic            frame_err_q;
    logic [15:0]     req_count_q;
    logic [31:0]     ram_rdata;
    logic            timeout, bad_cmd, late_byte;

    assign timeout   = (state_q == StGetAddr || state_q == StGetData) && !rx_valid_q
                       && (to_cnt_q == ToLast);
    assign bad_cmd   = (state_q == StIdle) && rx_valid_q
                       && (rx_shift_q != CmdWrite) && (rx_shift_q != CmdRead);
    assign late_byte = rx_valid_q && (state_q == StMem || state_q == StSend);
    // The first read byte comes straight from the RAM output register.
    assign tx_byte   = load_rd_q ? ram_rdata[7:0] : resp_q[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            is_write_q  <= 1'b0;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_q      <= '0;
            resp_left_q <= '0;
            load_rd_q   <= 1'b0;
            tx_start_q  <= 1'b0;
            to_cnt_q    <= '0;
            frame_err_q <= 1'b0;
            req_count_q <= '0;
        end else begin
            tx_start_q  <= 1'b0;
            frame_err_q <= rx_ferr_q | timeout | bad_cmd | late_byte;
            unique case (state_q)
                StIdle: begin
                    if (rx_valid_q) begin
                        if (bad_cmd) begin
                            resp_q      <= {24'h0, RspErr};
                            resp_left_q <= 3'd1;
                            load_rd_q   <= 1'b0;
                            tx_start_q  <= 1'b1;
                            state_q     <= StSend;
                        end else begin
                            is_write_q <= (rx_shift_q == CmdWrite);
                            byte_cnt_q <= '0;
                            to_cnt_q   <= '0;
                            state_q    <= StGetAddr;
                        end
                    end
                end
                StGetAddr, StGetData: begin
                    if (rx_valid_q) begin
                        to_cnt_q   <= '0;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (state_q == StGetAddr) begin
                            addr_q <= {rx_shift_q, addr_q[31:8]};
                            if (byte_cnt_q == 2'd3) state_q <= is_write_q ? StGetData : StMem;
                        end else begin
                            wdata_q <= {rx_shift_q, wdata_q[31:8]};
                            if (byte_cnt_q == 2'd3) state_q <= StMem;
                        end
                    end else if (timeout) begin
                        state_q <= StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q + ToW'(1);
                    end
                end
                StMem: begin
                    req_count_q <= req_count_q + 16'd1;
                    resp_q      <= {24'h0, RspAck};
                    resp_left_q <= is_write_q ? 3'd1 : 3'd4;
                    load_rd_q   <= !is_write_q;
                    tx_start_q  <= 1'b1;
                    state_q     <= StSend;
                end
                StSend: begin
                    if (load_rd_q) begin
                        resp_q    <= ram_rdata;
                        load_rd_q <= 1'b0;
                    end else if (tx_done) begin
                        if (resp_left_q == 3'd1) begin
                            state_q <= StIdle;
                        end else begin
                            resp_left_q <= resp_left_q - 3'd1;
                            resp_q      <= {8'h0, resp_q[31:8]};
                            tx_start_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Word RAM, not reset; the read port is registered every cycle.
    logic [31:0]       ram [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              unused_addr;

    assign idx         = addr_q[ADDR_W+1:2];
    assign unused_addr = ^{addr_q[31:ADDR_W+2], addr_q[1:0]};

    always_ff @(posedge clk) begin
        if (state_q == StMem && is_write_q) ram[idx] <= wdata_q;
        ram_rdata <= ram[idx];
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.frame_err = frame_err_q;
    assign bus.req_count = req_count_q;
endmodule
